fir_mc_seq: RTL and testbench
=============================

# fir_mc_seq

Time-shared, multi-channel FIR filter. One signed multiplier-accumulator serves all taps and channels. Each accepted input sample is stored in its channel's delay line, convolved with a runtime-loadable coefficient set, then rounded, shifted and saturated to the output width. It sits between the sample source (ADC front end or decimator) and downstream DSP. Use it where input rate times taps is well below the clock rate and per-tap multipliers are too costly.

## Interface
- IWIDTH, 16, signed input sample width
- CWIDTH, 16, signed coefficient width
- TAPS, 8, taps per channel (≥2)
- CHANNELS, 2, independent channels sharing one coefficient set (≥1)
- OWIDTH, 16, signed output width
- SHIFT, 15, arithmetic right shift applied to accumulator before saturation (0..IWIDTH+CWIDTH-1)
- clk  in  1  single clock; all logic on posedge
- rst  in  1  reset; synchronous, active-high
- coef_we  in  1  write one shadow coefficient
- coef_addr  in  $clog2(TAPS)  tap index of shadow write
- coef_data  in  CWIDTH  signed coefficient value
- coef_swap  in  1  pulse: copy shadow bank to active bank
- in_valid  in  1  input sample present
- in_ready  out  1  block can accept a sample
- in_data  in  IWIDTH  signed sample
- in_chan  in  $clog2(CHANNELS) (min 1)  channel of sample
- out_valid  out  1  one-cycle result strobe
- out_data  out  OWIDTH  signed filtered result
- out_chan  out  $clog2(CHANNELS) (min 1)  channel of result
- out_sat  out  1  result was clipped (qualified by out_valid)

## Operation
- Accumulator width AWIDTH = IWIDTH+CWIDTH+$clog2(TAPS); products and sums are sign-extended, with no internal overflow.
- Per-channel circular delay line of TAPS samples with its own write pointer. The pointer wraps TAPS-1→0.
- y = Σ_{k=0..TAPS-1} c[k]·x[n-k]; c[0] weights the newest sample.
- State machine:
  - IDLE: in_ready=1. On in_valid&in_ready, write the sample into delay line[in_chan], advance that channel's pointer, clear the accumulator, latch the channel, go to MAC.
  - MAC: one product per cycle for TAPS cycles, k=0..TAPS-1, then go to OUT.
  - OUT: compute r = (acc + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT. Saturate r to [-2^(OWIDTH-1), 2^(OWIDTH-1)-1] and set out_sat if clipped. Register out_data, out_chan, out_sat; pulse out_valid; go to IDLE.
- in_chan ≥ CHANNELS: the sample is accepted and discarded. No state change, no out_valid, and the block stays in IDLE.
- Coefficients:
  - Writes go to the shadow bank any cycle.
  - coef_addr ≥ TAPS: the write is ignored.
  - coef_swap copies shadow→active only in IDLE. If it arrives in MAC/OUT, it is held pending and applied in the first IDLE cycle; a sample accepted in that same cycle uses the new set.
  - The active bank never changes mid-convolution.
  - Simultaneous coef_we and coef_swap: the swap copies the pre-write shadow contents.
- Reset clears delay lines, pointers, both coefficient banks, the accumulator and the pending swap; state goes to IDLE. Reset mid-MAC abandons the sample and no out_valid follows.

## Timing
- Reset values: in_ready=0 while rst is asserted, 1 in the first cycle after release. out_valid=0, out_data=0, out_chan=0, out_sat=0.
- Sample accepted at edge E0. MAC products are added at edges E1..E_TAPS. Outputs are registered at edge E_{TAPS+1}.
- out_valid is high for exactly the cycle after E_{TAPS+1}. In that same cycle in_ready=1 again.
- Latency is TAPS+1 cycles from the accepting edge to the output edge. Maximum throughput is one sample per TAPS+2 cycles.
- in_ready=0 throughout MAC and OUT. in_valid during that time is not consumed; the source must hold it.
- out_data, out_chan and out_sat hold their values between strobes.

## Test plan
- Impulse: TAPS=8, SHIFT=0, OWIDTH=40, active coefs 1..8 (c[0]=1); ch0 samples 1,0,0,0,0,0,0,0,0 → out_data 1,2,3,4,5,6,7,8,0. Each out_valid arrives exactly 9 cycles after its accepting edge.
- Channel isolation: interleave ch0 impulse 100 with ch1 constant 0 → ch1 outputs all 0. The ch0 sequence matches the impulse case scaled by 100; out_chan is correct on every strobe.
- Round/saturate, defaults (SHIFT=15, OWIDTH=16), all c=0x7FFF:
  - steady input 0x7FFF → out 0x7FFF, out_sat=1
  - steady input 0x8000 → out 0x8000, out_sat=1
  - single c[0]=0x4000, sample 3 → 2 (1.5 rounds up), out_sat=0
- Coefficient swap while busy: load shadow with all 1, pulse coef_swap during MAC → the current result uses the old set and the next sample uses all 1. Also: a coef_addr=8 write leaves the bank unchanged, and in_chan=3 with CHANNELS=2 produces no out_valid.
- Reset mid-operation: assert rst at E3 of a convolution → no out_valid, outputs 0, in_ready=1 after release. A following impulse gives a clean response with delay lines and coefficients zero, i.e. output 0.
- Back-pressure: hold in_valid=1 continuously → one sample consumed every TAPS+2 cycles, none lost or duplicated.

Source files
------------

// File: rtl/fir_mc_seq.sv
// Time-shared multi-channel FIR filter.
// One signed multiply-accumulate unit walks the taps of one channel per
// sample. The result is rounded, shifted and saturated to OWIDTH bits.
// Coefficients live in a shadow bank and an active bank. A swap copies the
// shadow bank into the active bank only while the engine is idle.
module fir_mc_seq #(
  parameter int IWIDTH   = 16,
  parameter int CWIDTH   = 16,
  parameter int TAPS     = 8,
  parameter int CHANNELS = 2,
  parameter int OWIDTH   = 16,
  parameter int SHIFT    = 15
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               coef_we,
  input  logic [$clog2(TAPS)-1:0]                            coef_addr,
  input  logic [CWIDTH-1:0]                                  coef_data,
  input  logic                                               coef_swap,
  input  logic                                               in_valid,
  output logic                                               in_ready,
  input  logic [IWIDTH-1:0]                                  in_data,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] in_chan,
  output logic                                               out_valid,
  output logic [OWIDTH-1:0]                                  out_data,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] out_chan,
  output logic                                               out_sat
);

  localparam int AW     = $clog2(TAPS);
  localparam int CHW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW     = IWIDTH + CWIDTH;
  localparam int AWIDTH = PW + AW;
  // One guard bit keeps the rounding add from overflowing.
  localparam int RW     = AWIDTH + 1;
  // Wide enough to hold both the shifted sum and the output limits.
  localparam int XW     = ((RW > OWIDTH) ? RW : OWIDTH) + 1;

  localparam logic signed [RW-1:0] RND =
    (SHIFT > 0) ? (RW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [XW-1:0] OMAX_X = {{(XW-OWIDTH+1){1'b0}}, {(OWIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] OMIN_X = {{(XW-OWIDTH+1){1'b1}}, {(OWIDTH-1){1'b0}}};
  localparam logic [OWIDTH-1:0]    OMAX_O = {1'b0, {(OWIDTH-1){1'b1}}};
  localparam logic [OWIDTH-1:0]    OMIN_O = {1'b1, {(OWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t state_q, state_d;

  logic signed [IWIDTH-1:0] dline    [CHANNELS][TAPS];
  logic [AW-1:0]            wptr     [CHANNELS];
  logic signed [CWIDTH-1:0] coef_sh  [TAPS];
  logic signed [CWIDTH-1:0] coef_act [TAPS];
  logic                     swap_pend;

  logic [CHW-1:0]           chan_q;
  logic [AW-1:0]            rptr;
  logic [AW-1:0]            kcnt;
  logic signed [AWIDTH-1:0] acc;

  logic                     accept;
  logic                     do_swap;
  logic                     chan_ok;
  logic                     addr_ok;
  logic                     last_tap;
  logic signed [IWIDTH-1:0] x_cur;
  logic signed [CWIDTH-1:0] c_cur;
  logic signed [PW-1:0]     prod;

  logic signed [RW-1:0]     rsum;
  logic signed [RW-1:0]     rshift;
  logic signed [XW-1:0]     rext;
  logic                     sat_hi;
  logic                     sat_lo;
  logic [OWIDTH-1:0]        res_o;

  // The extra leading zero keeps these range checks meaningful when
  // TAPS or CHANNELS is not a power of two.
  assign chan_ok  = ({1'b0, in_chan} < (CHW+1)'(CHANNELS));
  assign addr_ok  = ({1'b0, coef_addr} < (AW+1)'(TAPS));
  assign last_tap = (kcnt == AW'(TAPS - 1));

  // MAC operands: the newest sample pairs with c[0], then walk back in time.
  assign x_cur = dline[chan_q][rptr];
  assign c_cur = coef_act[kcnt];
  assign prod  = PW'(x_cur) * PW'(c_cur);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state, handshake and swap permission.
  // NOTE: every signal is given a default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    do_swap  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = !rst;
        do_swap  = coef_swap || swap_pend;
        // A sample on a channel that does not exist is consumed and dropped.
        accept   = in_valid && chan_ok;
        if (accept) state_d = S_MAC;
      end
      S_MAC:   if (last_tap) state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Delay lines and per-channel write pointers.
  // NOTE: the delay lines are cleared on reset, so they are built from
  // flops and cannot be mapped onto a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wptr[c] <= '0;
        for (int t = 0; t < TAPS; t++) dline[c][t] <= '0;
      end
    end else if (accept) begin
      dline[in_chan][wptr[in_chan]] <= in_data;
      wptr[in_chan] <= (wptr[in_chan] == AW'(TAPS - 1)) ? '0 : wptr[in_chan] + AW'(1);
    end
  end

  // Shadow and active coefficient banks, with the deferred swap request.
  // NOTE: non-blocking assignments make a swap copy the shadow bank as it
  // stood before a write landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < TAPS; t++) begin
        coef_sh[t]  <= '0;
        coef_act[t] <= '0;
      end
      swap_pend <= 1'b0;
    end else begin
      if (do_swap) begin
        coef_act  <= coef_sh;
        swap_pend <= 1'b0;
      end else if (coef_swap) begin
        swap_pend <= 1'b1;
      end
      if (coef_we && addr_ok) coef_sh[coef_addr] <= coef_data;
    end
  end

  // Convolution engine: one tap per cycle while in MAC.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      kcnt   <= '0;
      rptr   <= '0;
      chan_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            acc    <= '0;
            kcnt   <= '0;
            rptr   <= wptr[in_chan];
            chan_q <= in_chan;
          end
        end
        S_MAC: begin
          acc  <= acc + {{(AWIDTH-PW){prod[PW-1]}}, prod};
          kcnt <= kcnt + AW'(1);
          rptr <= (rptr == '0) ? AW'(TAPS - 1) : rptr - AW'(1);
        end
        default: ;
      endcase
    end
  end

  // Round half up, arithmetic shift, then clip to the output range.
  always_comb begin
    rsum   = {acc[AWIDTH-1], acc} + RND;
    rshift = rsum >>> SHIFT;
    rext   = XW'(rshift);
    sat_hi = (rext > OMAX_X);
    sat_lo = (rext < OMIN_X);
    if (sat_hi)      res_o = OMAX_O;
    else if (sat_lo) res_o = OMIN_O;
    else             res_o = rext[OWIDTH-1:0];
  end

  // Output registers: strobe for one cycle and hold the data between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= (state_q == S_OUT);
      if (state_q == S_OUT) begin
        out_data <= res_o;
        out_chan <= chan_q;
        out_sat  <= sat_hi || sat_lo;
      end
    end
  end

endmodule

// File: tb/tb_fir_mc_seq.sv
// Self-checking bench for fir_mc_seq. A transaction-level model computes
// each filtered result when a sample is accepted, then releases it TAPS+1
// edges later. A single compare process checks every output each cycle.
// Directed scenarios also pin hand-computed values.
module tb_fir_mc_seq;

  localparam int IWIDTH   = 16;
  localparam int CWIDTH   = 16;
  localparam int TAPS     = 8;
  localparam int CHANNELS = 3;
  localparam int OWIDTH   = 16;
  localparam int SHIFT    = 15;
  localparam int AW       = $clog2(TAPS);
  localparam int CHW      = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              coef_we = 1'b0;
  logic [AW-1:0]     coef_addr = '0;
  logic [CWIDTH-1:0] coef_data = '0;
  logic              coef_swap = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [IWIDTH-1:0] in_data = '0;
  logic [CHW-1:0]    in_chan = '0;
  logic              out_valid;
  logic [OWIDTH-1:0] out_data;
  logic [CHW-1:0]    out_chan;
  logic              out_sat;

  fir_mc_seq #(
    .IWIDTH(IWIDTH), .CWIDTH(CWIDTH), .TAPS(TAPS),
    .CHANNELS(CHANNELS), .OWIDTH(OWIDTH), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst(rst),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_swap(coef_swap),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_chan(in_chan),
    .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint m_hist [CHANNELS][TAPS];  // [ch][0] is the newest sample
  longint m_sh   [TAPS];
  longint m_act  [TAPS];
  bit     m_pend;
  int     m_busy;                   // edges left until the result is registered
  longint m_res_data;
  int     m_res_chan;
  bit     m_res_sat;
  bit     e_valid;
  longint e_data;
  int     e_chan;
  bit     e_sat;
  bit     started = 1'b0;

  function automatic void ref_filter(input int ch, output longint y, output bit sat);
    longint sum = 0;
    longint r;
    longint omax = (longint'(1) << (OWIDTH - 1)) - 1;
    longint omin = -(longint'(1) << (OWIDTH - 1));
    longint rnd  = (SHIFT > 0) ? (longint'(1) << (SHIFT - 1)) : 0;
    for (int k = 0; k < TAPS; k++) sum += m_act[k] * m_hist[ch][k];
    r = (sum + rnd) >>> SHIFT;
    sat = 1'b1;
    if (r > omax)      y = omax;
    else if (r < omin) y = omin;
    else begin
      y   = r;
      sat = 1'b0;
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      foreach (m_hist[c, t]) m_hist[c][t] = 0;
      foreach (m_sh[t]) begin
        m_sh[t]  = 0;
        m_act[t] = 0;
      end
      m_pend  = 1'b0;
      m_busy  = 0;
      e_valid = 1'b0;
      e_data  = 0;
      e_chan  = 0;
      e_sat   = 1'b0;
      started = 1'b1;
    end else begin
      if (m_busy == 0 && (coef_swap || m_pend)) begin
        m_act  = m_sh;
        m_pend = 1'b0;
      end else if (coef_swap) begin
        m_pend = 1'b1;
      end
      e_valid = 1'b0;
      if (m_busy == 0) begin
        if (in_valid && int'(in_chan) < CHANNELS) begin
          for (int k = TAPS - 1; k > 0; k--) m_hist[in_chan][k] = m_hist[in_chan][k-1];
          m_hist[in_chan][0] = longint'($signed(in_data));
          ref_filter(int'(in_chan), m_res_data, m_res_sat);
          m_res_chan = int'(in_chan);
          m_busy = TAPS + 1;
        end
      end else begin
        m_busy--;
        if (m_busy == 0) begin
          e_valid = 1'b1;
          e_data  = m_res_data;
          e_chan  = m_res_chan;
          e_sat   = m_res_sat;
        end
      end
      if (coef_we && int'(coef_addr) < TAPS) m_sh[coef_addr] = longint'($signed(coef_data));
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (started) begin
      check("in_ready",  in_ready, (m_busy == 0 && !rst));
      check("out_valid", out_valid, e_valid);
      check("out_data",  $signed(out_data), e_data);
      check("out_chan",  out_chan, e_chan);
      check("out_sat",   out_sat, e_sat);
    end
  end

  // Strobe collector for the hand-computed expectations.
  int sq_data[$];
  int sq_chan[$];
  int sq_sat[$];
  int sq_cyc[$];
  int n_strobe = 0;

  always @(negedge clk) begin
    if (started && out_valid === 1'b1) begin
      sq_data.push_back(int'($signed(out_data)));
      sq_chan.push_back(int'(out_chan));
      sq_sat.push_back(int'(out_sat));
      sq_cyc.push_back(cyc);
      n_strobe++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input int data, output int acc_cyc);
    int  wait_n = 0;
    bit  r = 1'b0;
    logic [31:0] dv = data;
    logic [31:0] cv = ch;
    in_chan  = cv[CHW-1:0];
    in_data  = dv[IWIDTH-1:0];
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      wait_n++;
    end while (!r && wait_n < 40);
    in_valid = 1'b0;
    acc_cyc  = cyc;
    check("sample_accepted", r, 1);
  endtask

  task automatic wait_strobes(input int n);
    int target = n_strobe + n;
    int t = 0;
    while (n_strobe < target && t < 100) begin
      tick();
      t++;
    end
    check("strobe_arrived", (n_strobe >= target), 1);
  endtask

  task automatic wr_coef(input int addr, input int data);
    logic [31:0] av = addr;
    logic [31:0] dv = data;
    coef_we   = 1'b1;
    coef_addr = av[AW-1:0];
    coef_data = dv[CWIDTH-1:0];
    tick();
    coef_we = 1'b0;
  endtask

  task automatic pulse_swap();
    coef_swap = 1'b1;
    tick();
    coef_swap = 1'b0;
  endtask

  task automatic clear_q();
    sq_data.delete();
    sq_chan.delete();
    sq_sat.delete();
    sq_cyc.delete();
  endtask

  // ---------------- main sequence ----------------
  int a;
  int n0;
  int acc_imp[9];
  int imp_exp[9];
  int iso_exp[9];
  int bp_acc[20];
  bit r;

  initial begin
    imp_exp = '{1024, 2048, 3072, 4096, 5120, 6144, 7168, 8192, 0};
    iso_exp = '{6, 13, 19, 25, 31, 38, 44, 50, 0};

    // Reset
    rst = 1'b1;
    tick(3);
    check("ready_during_reset", in_ready, 0);
    rst = 1'b0;
    #1;
    check("reset_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_chan", out_chan, 0);
    check("reset_out_sat", out_sat, 0);

    // Impulse: c[k] = (k+1)*2048, x = 2^14, giving (k+1)*1024 after >>>15
    for (int k = 0; k < TAPS; k++) wr_coef(k, (k + 1) * 2048);
    pulse_swap();
    clear_q();
    for (int i = 0; i < 9; i++) begin
      send(0, (i == 0) ? 16384 : 0, acc_imp[i]);
      wait_strobes(1);
    end
    for (int i = 0; i < 9; i++) begin
      check("impulse_data", sq_data[i], imp_exp[i]);
      check("impulse_latency", sq_cyc[i] - acc_imp[i], TAPS + 1);
    end

    // Channel isolation: ch0 impulse of 100 interleaved with ch1 zeros
    clear_q();
    for (int i = 0; i < 9; i++) begin
      send(0, (i == 0) ? 100 : 0, a);
      wait_strobes(1);
      send(1, 0, a);
      wait_strobes(1);
    end
    for (int i = 0; i < 9; i++) begin
      check("iso_ch0_data", sq_data[2*i], iso_exp[i]);
      check("iso_ch0_chan", sq_chan[2*i], 0);
      check("iso_ch1_data", sq_data[2*i+1], 0);
      check("iso_ch1_chan", sq_chan[2*i+1], 1);
    end

    // Swap requested mid-convolution; the next sample is presented while busy
    for (int k = 0; k < TAPS; k++) wr_coef(k, 1);
    clear_q();
    send(2, 30000, a);
    tick(2);
    pulse_swap();
    send(2, 30000, a);
    wait_strobes(1);
    check("swap_old_set", sq_data[0], 1875);
    check("swap_new_set", sq_data[1], 2);

    // Sample on a channel that does not exist is dropped
    n0 = n_strobe;
    send(3, 12345, a);
    tick(TAPS + 4);
    check("discard_no_strobe", n_strobe, n0);

    // Rounding and saturation with all coefficients 0x7FFF
    for (int k = 0; k < TAPS; k++) wr_coef(k, 32'h7FFF);
    pulse_swap();
    clear_q();
    for (int i = 0; i < 9; i++) begin
      send(0, 32767, a);
      wait_strobes(1);
    end
    check("sat_first_data", sq_data[0], 32766);
    check("sat_first_flag", sq_sat[0], 0);
    check("sat_pos_data", sq_data[8], 32767);
    check("sat_pos_flag", sq_sat[8], 1);
    clear_q();
    for (int i = 0; i < TAPS; i++) begin
      send(0, -32768, a);
      wait_strobes(1);
    end
    check("sat_neg_data", sq_data[TAPS-1], -32768);
    check("sat_neg_flag", sq_sat[TAPS-1], 1);
    wr_coef(0, 32'h4000);
    for (int k = 1; k < TAPS; k++) wr_coef(k, 0);
    pulse_swap();
    clear_q();
    send(1, 3, a);
    wait_strobes(1);
    check("round_half_up", sq_data[0], 2);
    check("round_no_sat", sq_sat[0], 0);

    // Reset asserted so that it is sampled on the third MAC edge
    n0 = n_strobe;
    send(0, 5000, a);
    tick(2);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(TAPS + 4);
    check("rst_mid_no_strobe", n_strobe, n0);
    check("rst_mid_out_data", out_data, 0);
    clear_q();
    send(0, 1, a);
    wait_strobes(1);
    check("post_rst_impulse", sq_data[0], 0);
    check("post_rst_sat", sq_sat[0], 0);

    // Back-pressure: in_valid held continuously across 20 samples
    for (int k = 0; k < TAPS; k++) wr_coef(k, int'($urandom));
    pulse_swap();
    n0 = n_strobe;
    for (int i = 0; i < 20; i++)
      send(int'($urandom_range(0, CHANNELS - 1)), int'($urandom), bp_acc[i]);
    wait_strobes(1);
    for (int i = 1; i < 20; i++) check("bp_spacing", bp_acc[i] - bp_acc[i-1], TAPS + 2);
    check("bp_count", n_strobe - n0, 20);

    // Random traffic: coefficient writes, swaps, samples on any channel id
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (in_valid && r) in_valid = 1'b0;
      coef_we   = ($urandom_range(0, 99) < 15);
      coef_addr = AW'($urandom_range(0, TAPS - 1));
      coef_data = CWIDTH'($urandom);
      coef_swap = ($urandom_range(0, 99) < 4);
      if (!in_valid && $urandom_range(0, 99) < 40) begin
        in_valid = 1'b1;
        in_chan  = CHW'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0:       in_data = 16'h7FFF;
          1:       in_data = 16'h8000;
          default: in_data = IWIDTH'($urandom);
        endcase
      end
    end
    coef_we   = 1'b0;
    coef_swap = 1'b0;
    in_valid  = 1'b0;
    tick(TAPS + 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
